// File: rtl/gba_gpu_pkg.sv
// ---------------------------------------------------------------------------
// gba_gpu_pkg
// Shared constants for the GPU pixel pipeline.
//   TRANSPARENT_PIXEL : pixel value that means "nothing drawn here"
//                       (bit15 set, colour don't-care).
//   PIXELCOUNT        : visible pixels per scanline.
//   XBITS             : width of a pixel column index.
// ---------------------------------------------------------------------------
package gba_gpu_pkg;

  localparam logic [15:0] TRANSPARENT_PIXEL = 16'h8000;
  localparam int          PIXELCOUNT        = 240;
  localparam int          XBITS             = 8;

endpackage

// File: rtl/gba_linebuffer_bank.sv
// ---------------------------------------------------------------------------
// gba_linebuffer_bank
// One scanline worth of BGR555 colour storage: PIXELCOUNT x 15 bit RAM,
// one write port and one synchronous read port. There is no reset on the
// storage; the owner masks stale entries with its own valid flags.
// Ports:
//   fclk  : clock
//   we    : write enable, waddr/wdata written on the rising edge
//   waddr : write column (must be < PIXELCOUNT when we=1)
//   wdata : BGR555 colour
//   re    : read enable, rdata updates on the rising edge, holds otherwise
//   raddr : read column (must be < PIXELCOUNT when re=1)
//   rdata : registered read data
// ---------------------------------------------------------------------------
module gba_linebuffer_bank
  import gba_gpu_pkg::*;
#(
  parameter int PIXELCOUNT = gba_gpu_pkg::PIXELCOUNT,
  parameter int XBITS      = gba_gpu_pkg::XBITS
) (
  input  logic             fclk,
  input  logic             we,
  input  logic [XBITS-1:0] waddr,
  input  logic [14:0]      wdata,
  input  logic             re,
  input  logic [XBITS-1:0] raddr,
  output logic [14:0]      rdata
);

  logic [14:0] mem [PIXELCOUNT];

  // Write port: the caller guarantees waddr is in range whenever we is set.
  always_ff @(posedge fclk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: registered output that only moves when a read is issued, so
  // the last fetched colour stays put between reads.
  always_ff @(posedge fclk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/gba_bg_linebuffer.sv
// ---------------------------------------------------------------------------
// gba_bg_linebuffer
// Double-banked scanline buffer between the background drawers and the
// compositor. The drawers fill bank "wbank" with sparse pixel writes for
// line N while the compositor reads line N-1 from the other bank. Columns
// never written on a line read back as transparent.
// Ports:
//   fclk         : clock
//   reset        : asynchronous active-high reset
//   line_trigger : one-cycle pulse at line start, swaps the banks
//   bg_enable    : 0 forces every read result to transparent
//   pixel_we     : drawer write strobe
//   pixel_x      : drawer column
//   pixeldata    : [15] transparent flag, [14:0] BGR555
//   rd_en        : compositor read request
//   rd_x         : compositor column
//   rd_data      : read pixel, valid the cycle after rd_en
//   rd_valid     : rd_en delayed by one cycle
//   wbank        : bank currently being written
// ---------------------------------------------------------------------------
module gba_bg_linebuffer
  import gba_gpu_pkg::*;
#(
  parameter int PIXELCOUNT = gba_gpu_pkg::PIXELCOUNT,
  parameter int XBITS      = gba_gpu_pkg::XBITS
) (
  input  logic             fclk,
  input  logic             reset,
  input  logic             line_trigger,
  input  logic             bg_enable,
  input  logic             pixel_we,
  input  logic [XBITS-1:0] pixel_x,
  input  logic [15:0]      pixeldata,
  input  logic             rd_en,
  input  logic [XBITS-1:0] rd_x,
  output logic [15:0]      rd_data,
  output logic             rd_valid,
  output logic             wbank
);

  // One extra bit so a 240-wide line still compares correctly when XBITS
  // could only just hold PIXELCOUNT-1.
  localparam logic [XBITS:0] X_LIMIT = (XBITS+1)'(PIXELCOUNT);

  logic [1:0][PIXELCOUNT-1:0] valid_bits;

  logic        wr_in_range;
  logic        rd_in_range;
  logic        wr_accept;
  logic        rd_accept;
  logic        rbank;
  logic [1:0]  ram_we;
  logic [1:0]  ram_re;
  logic [14:0] ram_q [2];

  // Registered read qualifiers; they only update on rd_en so rd_data holds.
  logic        rd_hit;
  logic        rd_bank_q;

  assign rbank       = ~wbank;
  assign wr_in_range = ({1'b0, pixel_x} < X_LIMIT);
  assign rd_in_range = ({1'b0, rd_x} < X_LIMIT);
  assign wr_accept   = pixel_we && wr_in_range;
  assign rd_accept   = rd_en && rd_in_range;

  // Steer the RAM strobes: a transparent write only clears the valid flag,
  // so the colour RAM is written only for opaque pixels.
  always_comb begin
    ram_we = '0;
    ram_re = '0;
    if (wr_accept && !pixeldata[15]) begin
      ram_we[wbank] = 1'b1;
    end
    if (rd_accept) begin
      ram_re[rbank] = 1'b1;
    end
  end

  gba_linebuffer_bank #(
    .PIXELCOUNT (PIXELCOUNT),
    .XBITS      (XBITS)
  ) u_bank0 (
    .fclk  (fclk),
    .we    (ram_we[0]),
    .waddr (pixel_x),
    .wdata (pixeldata[14:0]),
    .re    (ram_re[0]),
    .raddr (rd_x),
    .rdata (ram_q[0])
  );

  gba_linebuffer_bank #(
    .PIXELCOUNT (PIXELCOUNT),
    .XBITS      (XBITS)
  ) u_bank1 (
    .fclk  (fclk),
    .we    (ram_we[1]),
    .waddr (pixel_x),
    .wdata (pixeldata[14:0]),
    .re    (ram_re[1]),
    .raddr (rd_x),
    .rdata (ram_q[1])
  );

  // Bank select: a line_trigger flips the write bank. Any write in the same
  // cycle still uses the pre-swap value, so the last pixel of a line lands in
  // the bank that is about to become readable.
  always_ff @(posedge fclk or posedge reset) begin
    if (reset) begin
      wbank <= 1'b0;
    end else if (line_trigger) begin
      wbank <= ~wbank;
    end
  end

  // Valid flags: on a line_trigger the bank about to be reused for writing
  // (the old read bank) is wiped, which is what makes unwritten columns read
  // back transparent. Writes and the wipe never target the same bank in one
  // cycle, so their order here does not matter.
  always_ff @(posedge fclk or posedge reset) begin
    if (reset) begin
      valid_bits <= '0;
    end else begin
      if (line_trigger) begin
        valid_bits[rbank] <= '0;
      end
      if (wr_accept) begin
        valid_bits[wbank][pixel_x] <= ~pixeldata[15];
      end
    end
  end

  // Read qualifiers are sampled alongside the RAM read so the colour and its
  // mask describe the same request. Reset drops an in-flight read.
  always_ff @(posedge fclk or posedge reset) begin
    if (reset) begin
      rd_valid  <= 1'b0;
      rd_hit    <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_hit    <= bg_enable && rd_in_range && valid_bits[rbank][rd_x];
        rd_bank_q <= rbank;
      end
    end
  end

  assign rd_data = rd_hit ? {1'b0, ram_q[rd_bank_q]} : TRANSPARENT_PIXEL;

endmodule

// File: tb/tb_gba_bg_linebuffer.sv
// ---------------------------------------------------------------------------
// tb_gba_bg_linebuffer
// Directed and random stimulus for gba_bg_linebuffer, checked against a
// reference model that keeps each bank as an array of whole 16-bit pixels
// (transparent by default) and swaps/clears them on each line start.
// ---------------------------------------------------------------------------
module tb_gba_bg_linebuffer;

  localparam int PIXELS = 240;

  logic        fclk;
  logic        reset;
  logic        line_trigger;
  logic        bg_enable;
  logic        pixel_we;
  logic [7:0]  pixel_x;
  logic [15:0] pixeldata;
  logic        rd_en;
  logic [7:0]  rd_x;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        wbank;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: per bank, the pixel a read would return.
  logic [15:0] model_bank [2][PIXELS];
  logic        model_wbank;
  logic [15:0] model_last_rd;

  gba_bg_linebuffer dut (
    .fclk         (fclk),
    .reset        (reset),
    .line_trigger (line_trigger),
    .bg_enable    (bg_enable),
    .pixel_we     (pixel_we),
    .pixel_x      (pixel_x),
    .pixeldata    (pixeldata),
    .rd_en        (rd_en),
    .rd_x         (rd_x),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .wbank        (wbank)
  );

  // Free-running clock, period 10.
  initial begin
    fclk = 1'b0;
    forever #5 fclk = ~fclk;
  end

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < PIXELS; i++) begin
        model_bank[b][i] = 16'h8000;
      end
    end
    model_wbank   = 1'b0;
    model_last_rd = 16'h8000;
  endtask

  task automatic check_output(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs on the falling edge, advance the model at
  // the rising edge, then check outputs 1 time unit later.
  task automatic apply_stimulus(input logic we, input int x,
                                input logic [15:0] data, input logic trig,
                                input logic rden, input int rx,
                                input logic bgen, input string tag);
    logic [15:0] exp_rd;
    logic        nb;
    @(negedge fclk);
    pixel_we     = we;
    pixel_x      = x[7:0];
    pixeldata    = data;
    line_trigger = trig;
    rd_en        = rden;
    rd_x         = rx[7:0];
    bg_enable    = bgen;
    @(posedge fclk);
    nb = ~model_wbank;
    if (rden) begin
      if (bgen && rx < PIXELS) exp_rd = model_bank[nb][rx];
      else                     exp_rd = 16'h8000;
      model_last_rd = exp_rd;
    end
    if (we && x < PIXELS) begin
      model_bank[model_wbank][x] = data[15] ? 16'h8000 : data;
    end
    if (trig) begin
      model_wbank = ~model_wbank;
      for (int i = 0; i < PIXELS; i++) model_bank[model_wbank][i] = 16'h8000;
    end
    #1;
    check_output({tag, ".rd_valid"}, {15'd0, rd_valid}, {15'd0, rden});
    check_output({tag, ".rd_data"}, rd_data, model_last_rd);
    check_output({tag, ".wbank"}, {15'd0, wbank}, {15'd0, model_wbank});
  endtask

  task automatic idle_write(input int x, input logic [15:0] data, input string tag);
    apply_stimulus(1'b1, x, data, 1'b0, 1'b0, 0, 1'b1, tag);
  endtask

  task automatic swap(input string tag);
    apply_stimulus(1'b0, 0, 16'h0, 1'b1, 1'b0, 0, 1'b1, tag);
  endtask

  task automatic read_px(input int x, input string tag);
    apply_stimulus(1'b0, 0, 16'h0, 1'b0, 1'b1, x, 1'b1, tag);
  endtask

  initial begin
    pixel_we = 0; pixel_x = 0; pixeldata = 0; line_trigger = 0;
    rd_en = 0; rd_x = 0; bg_enable = 1;
    model_reset();

    // Reset state
    reset = 1'b1;
    #12;
    check_output("reset.wbank", {15'd0, wbank}, 16'd0);
    check_output("reset.rd_valid", {15'd0, rd_valid}, 16'd0);
    check_output("reset.rd_data", rd_data, 16'h8000);
    @(negedge fclk);
    reset = 1'b0;

    // Empty line reads transparent everywhere
    swap("empty.swap");
    for (int i = 0; i < PIXELS; i++) read_px(i, "empty.read");
    apply_stimulus(1'b0, 0, 16'h0, 1'b0, 1'b0, 0, 1'b1, "empty.hold");

    // Basic write then read after swap, including the last column
    idle_write(5, 16'h1234, "basic.w5");
    idle_write(239, 16'h7FFF, "basic.w239");
    swap("basic.swap");
    read_px(5, "basic.r5");
    read_px(239, "basic.r239");
    read_px(6, "basic.r6");

    // Valid bits wiped when a bank is reused
    idle_write(10, 16'h0001, "reuse.w10");
    swap("reuse.swap1");
    swap("reuse.swap2");
    read_px(10, "reuse.r10");
    swap("reuse.swap3");
    read_px(10, "reuse.r10b");

    // Write coincident with line_trigger lands in the completing line
    apply_stimulus(1'b1, 20, 16'h0ABC, 1'b1, 1'b0, 0, 1'b1, "coinc.wtrig");
    read_px(20, "coinc.r20");
    swap("coinc.swap");
    read_px(20, "coinc.r20gone");

    // Transparent overwrite, out of range write, bg_enable masking
    idle_write(3, 16'h0111, "mask.w3");
    idle_write(3, 16'h8000, "mask.w3t");
    idle_write(240, 16'h1234, "mask.w240");
    idle_write(5, 16'h0555, "mask.w5");
    idle_write(6, 16'h0666, "mask.w6a");
    idle_write(6, 16'h0777, "mask.w6b");
    swap("mask.swap");
    read_px(3, "mask.r3");
    read_px(240, "mask.r240");
    apply_stimulus(1'b0, 0, 16'h0, 1'b0, 1'b1, 5, 1'b0, "mask.r5off");
    read_px(5, "mask.r5on");
    read_px(6, "mask.r6last");
    read_px(255, "mask.r255");

    // Back-to-back triggers clear both banks
    idle_write(9, 16'h0099, "b2b.w9");
    swap("b2b.swap1");
    swap("b2b.swap2");
    read_px(9, "b2b.r9");
    read_px(5, "b2b.r5");

    // Reset mid-line with a read in flight
    idle_write(7, 16'h0707, "rst.w7");
    swap("rst.swap");
    read_px(7, "rst.r7pre");
    reset = 1'b1;
    model_reset();
    #1;
    check_output("rst.wbank", {15'd0, wbank}, 16'd0);
    check_output("rst.rd_valid", {15'd0, rd_valid}, 16'd0);
    check_output("rst.rd_data", rd_data, 16'h8000);
    @(negedge fclk);
    reset = 1'b0;
    swap("rst.swap2");
    read_px(7, "rst.r7");

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      apply_stimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                     16'($urandom), ($urandom_range(0, 19) == 0),
                     1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                     ($urandom_range(0, 7) != 0), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
